sram_avalon_sequencer: RTL and testbench

//  Avalon-MM slave that turns single-word bus reads/writes into timed async-SRAM

---
 rtl/sram_seq_pkg.sv | 16 +
 rtl/sram_avalon_sequencer.sv | 176 +++++++++++++++++
 tb/tb_sram_avalon_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_seq_pkg.sv
// Shared types and widths for the Avalon-MM to async-SRAM sequencer.
package sram_seq_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR_S = 3'd2,
    WR_P = 3'd3,
    WR_H = 3'd4
  } state_e;

endpackage

// File: rtl/sram_avalon_sequencer.sv
// Avalon-MM slave that converts single-word reads/writes into timed async-SRAM
// cycles; every SRAM pin and the read data are registered.
module sram_avalon_sequencer
  import sram_seq_pkg::*;
#(
  parameter int unsigned READ_WAIT = 2,
  parameter int unsigned WR_SETUP  = 1,
  parameter int unsigned WR_PULSE  = 2,
  parameter int unsigned WR_HOLD   = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [SRAM_AW-1:0]   avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [1:0]           avs_byteenable,
  input  logic [SRAM_DW-1:0]   avs_writedata,
  output logic                 avs_waitrequest,
  output logic [SRAM_DW-1:0]   avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [SRAM_AW-1:0]   oSRAM_ADDR,
  output logic [SRAM_DW-1:0]   oSRAM_DATA,
  output logic                 oSRAM_CE_N,
  output logic                 oSRAM_OE_N,
  output logic                 oSRAM_WE_N,
  output logic                 oSRAM_UB_N,
  output logic                 oSRAM_LB_N,
  input  logic [SRAM_DW-1:0]   iSRAM_DATA
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   data_q, data_d;
  logic [1:0]           be_q, be_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 ub_n_q, ub_n_d;
  logic                 lb_n_q, lb_n_d;
  logic [SRAM_DW-1:0]   rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wait_q, wait_d;

  // State, counter, latched request and registered pins
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
    end
  end

  // Next state: counter holds remaining cycles minus one in the current phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (avs_write || avs_read) begin
          addr_d = avs_address;
          data_d = avs_writedata;
          be_d   = avs_byteenable;
        end
        // Write wins when both are requested; the read is dropped
        if (avs_write) begin
          state_d = WR_S;
          cnt_d   = CNT_W'(WR_SETUP - 1);
        end else if (avs_read) begin
          state_d = RD;
          cnt_d   = CNT_W'(READ_WAIT - 1);
        end
      end
      RD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_S: begin
        if (cnt_q == '0) begin
          state_d = WR_P;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_P: begin
        if (cnt_q == '0) begin
          state_d = WR_H;
          cnt_d   = CNT_W'(WR_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_H: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values follow the state being entered so they line up with it
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wait_d   = (state_d != IDLE);
    case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      WR_S, WR_H: begin
        ce_n_d = 1'b0;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      WR_P: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      default: ;
    endcase
    if (state_q == RD && state_d == IDLE) begin
      rdata_d  = iSRAM_DATA;
      rvalid_d = 1'b1;
    end
  end

  assign avs_waitrequest   = wait_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign oSRAM_ADDR        = addr_q;
  assign oSRAM_DATA        = data_q;
  assign oSRAM_CE_N        = ce_n_q;
  assign oSRAM_OE_N        = oe_n_q;
  assign oSRAM_WE_N        = we_n_q;
  assign oSRAM_UB_N        = ub_n_q;
  assign oSRAM_LB_N        = lb_n_q;

endmodule

// File: tb/tb_sram_avalon_sequencer.sv
// Bench for sram_avalon_sequencer: behavioural async SRAM on the pin side and a
// word-level reference memory for expected read data.
module tb_sram_avalon_sequencer;

  localparam int unsigned RW = 2;
  localparam int unsigned WS = 1;
  localparam int unsigned WP = 2;
  localparam int unsigned WH = 1;
  localparam logic [17:0] ABORT_ADDR = 18'h2AAAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] address = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  byteen = '0;
  logic [15:0] wdata = '0;
  logic        waitreq;
  logic [15:0] rdata;
  logic        rvalid;
  logic [17:0] s_addr;
  logic [15:0] s_wdata;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] s_rdata;

  always #5 clk = ~clk;

  sram_avalon_sequencer #(
    .READ_WAIT(RW), .WR_SETUP(WS), .WR_PULSE(WP), .WR_HOLD(WH)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .avs_address(address), .avs_read(rd), .avs_write(wr),
    .avs_byteenable(byteen), .avs_writedata(wdata),
    .avs_waitrequest(waitreq), .avs_readdata(rdata), .avs_readdatavalid(rvalid),
    .oSRAM_ADDR(s_addr), .oSRAM_DATA(s_wdata), .oSRAM_CE_N(ce_n),
    .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n), .oSRAM_UB_N(ub_n), .oSRAM_LB_N(lb_n),
    .iSRAM_DATA(s_rdata)
  );

  // Behavioural async SRAM behind the pin wrapper
  logic [15:0] sram [0:262143];
  assign s_rdata = (!ce_n && !oe_n && we_n) ? sram[s_addr] : 16'hDEAD;
  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) sram[s_addr][15:8] <= s_wdata[15:8];
      if (!lb_n) sram[s_addr][7:0]  <= s_wdata[7:0];
    end
  end

  // Reference: what each word should hold after the accepted writes
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction
  function automatic void ref_wr(input logic [17:0] a, input logic [15:0] d,
                                 input logic [1:0] b);
    logic [15:0] w;
    w = ref_rd(a);
    if (b[1]) w[15:8] = d[15:8];
    if (b[0]) w[7:0]  = d[7:0];
    ref_mem[int'(a)] = w;
  endfunction

  typedef struct {
    logic [15:0] d;
    int          t;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int reads_issued = 0;
  int rdv_count = 0;
  int we_run = 0;
  int idle_viol = 0;
  int stab_viol = 0;
  logic        strobe_prev = 1'b0;
  logic [35:0] bus_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pin-side monitor: read results, write pulse width, idle and stability rules
  always @(negedge clk) begin
    if (!rst_n) begin
      we_run      = 0;
      strobe_prev = 1'b0;
    end else begin
      if (rvalid) begin
        rdv_count++;
        if (exp_q.size() > 0) begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("rdata", 32'(rdata), 32'(e.d));
          chk("rd_latency", 32'(cyc - e.t), 32'(RW + 1));
        end
      end
      if (!we_n) we_run++;
      else if (we_run > 0) begin
        chk("we_pulse", 32'(we_run), 32'(WP));
        we_run = 0;
      end
      if (!waitreq && {ce_n, oe_n, we_n, ub_n, lb_n} != 5'b11111) idle_viol++;
      if ((!we_n || !oe_n) && strobe_prev && {s_addr, s_wdata, ub_n, lb_n} != bus_prev)
        stab_viol++;
      strobe_prev = !we_n || !oe_n;
      bus_prev    = {s_addr, s_wdata, ub_n, lb_n};
    end
  end

  // Wait (at negedges) until the slave is ready; returns the accept cycle
  task automatic wait_ready(output int t);
    int n;
    n = 0;
    while (waitreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
    t = cyc;
  endtask

  task automatic bus_op(input logic r, input logic w, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    int t;
    int busy;
    @(negedge clk);
    rd = r; wr = w; address = a; wdata = d; byteen = b;
    wait_ready(t);
    if (w) ref_wr(a, d, b);
    else if (r) begin
      rd_exp_t e;
      e.d = ref_rd(a);
      e.t = t;
      exp_q.push_back(e);
      reads_issued++;
    end
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    busy = 0;
    @(negedge clk);
    while (waitreq && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    if (w) chk("wr_busy", 32'(busy), 32'(WS + WP + WH));
    else   chk("rd_busy", 32'(busy), 32'(RW));
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int hi;
    int n;
    logic [17:0] pool [6];
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

    // 1: reset release then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_ce_n", 32'(ce_n), 32'(1));
    chk("rst_oe_n", 32'(oe_n), 32'(1));
    chk("rst_we_n", 32'(we_n), 32'(1));
    chk("rst_waitreq", 32'(waitreq), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_addr", 32'(s_addr), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));

    // 2: basic write then read
    bus_op(1'b0, 1'b1, 18'h00010, 16'hA55A, 2'b11);
    bus_op(1'b1, 1'b0, 18'h00010, 16'h0000, 2'b11);

    // 3: top address, upper-byte write, null byte-enable write
    bus_op(1'b0, 1'b1, 18'h3FFFF, 16'h1234, 2'b11);
    bus_op(1'b0, 1'b1, 18'h3FFFF, 16'hFF00, 2'b10);
    bus_op(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00);
    bus_op(1'b0, 1'b1, 18'h3FFFF, 16'hBEEF, 2'b00);
    bus_op(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11);

    // 4: three reads with the request held on the bus
    hi = 0;
    @(negedge clk);
    rd = 1'b1; address = 18'h00010;
    for (int k = 0; k < 3; k++) begin
      rd_exp_t e;
      n = 0;
      while (waitreq && n < 50) begin
        hi++; n++;
        @(negedge clk);
      end
      if (n >= 50) chk("b2b_timeout", 32'(n), 32'(0));
      e.d = ref_rd(address);
      e.t = cyc;
      exp_q.push_back(e);
      reads_issued++;
      @(posedge clk);
      #1 address = (k == 0) ? 18'h3FFFF : 18'h00010;
      if (k == 2) rd = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (waitreq && n < 50) begin
      hi++; n++;
      @(negedge clk);
    end
    chk("b2b_wait_hi", 32'(hi), 32'(3 * RW));

    // 5: read and write together -> write only
    bus_op(1'b1, 1'b1, 18'h00020, 16'h0F0F, 2'b11);
    bus_op(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11);

    // 6a: reset during the write pulse
    @(negedge clk);
    wr = 1'b1; address = ABORT_ADDR; wdata = 16'h5555; byteen = 2'b11;
    wait_ready(t);
    @(posedge clk);
    #1 wr = 1'b0;
    n = 0;
    @(negedge clk);
    while (we_n && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("abort_wr_reached_pulse", 32'(we_n), 32'(0));
    #2 rst_n = 1'b0;
    we_run = 0;
    #1;
    chk("abort_wr_we_n", 32'(we_n), 32'(1));
    chk("abort_wr_ce_n", 32'(ce_n), 32'(1));
    chk("abort_wr_waitreq", 32'(waitreq), 32'(0));
    release_reset();

    // 6b: reset during a read
    @(negedge clk);
    rd = 1'b1; address = 18'h00020;
    wait_ready(t);
    begin
      rd_exp_t e;
      e.d = ref_rd(18'h00020);
      e.t = t;
      exp_q.push_back(e);
      reads_issued++;
    end
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    chk("abort_rd_oe_low", 32'(oe_n), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_oe_n", 32'(oe_n), 32'(1));
    chk("abort_rd_ce_n", 32'(ce_n), 32'(1));
    chk("abort_rd_rvalid", 32'(rvalid), 32'(0));
    reads_issued -= exp_q.size();
    exp_q.delete();
    release_reset();
    bus_op(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11);

    // Randomized mix over a small address pool
    foreach (pool[i]) begin
      pool[i] = 18'($urandom);
      if (pool[i] == ABORT_ADDR) pool[i] = 18'h00100;
    end
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [17:0] a;
      op = int'($urandom_range(0, 9));
      a  = pool[$urandom_range(0, 5)];
      if (op < 4)      bus_op(1'b0, 1'b1, a, 16'($urandom), 2'($urandom));
      else if (op < 9) bus_op(1'b1, 1'b0, a, 16'($urandom), 2'($urandom));
      else             bus_op(1'b1, 1'b1, a, 16'($urandom), 2'($urandom));
    end

    repeat (6) @(negedge clk);
    chk("rdv_count", 32'(rdv_count), 32'(reads_issued));
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
    chk("idle_strobes", 32'(idle_viol), 32'(0));
    chk("strobe_stable", 32'(stab_viol), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
